// File: rtl/register_file.sv
// 31 x BITSIZE general-purpose register file with a hard-wired zero register (XZR),
// three combinational read ports, one write port and a committed-write counter.

module rf_read_port #(
  parameter int BITSIZE = 64,
  parameter int REGSIZE = 5
) (
  input  logic [2**REGSIZE-1:0][BITSIZE-1:0] regs,
  input  logic [REGSIZE-1:0]                 idx,
  output logic [BITSIZE-1:0]                 data
);
  assign data = regs[idx];
endmodule

module register_file #(
  parameter int BITSIZE = 64,
  parameter int REGSIZE = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REGSIZE-1:0] read_reg1,
  input  logic [REGSIZE-1:0] read_reg2,
  input  logic [REGSIZE-1:0] write_reg,
  input  logic [BITSIZE-1:0] write_data,
  input  logic               RegWrite,
  input  logic [REGSIZE-1:0] dbg_reg,
  output logic [BITSIZE-1:0] read_data1,
  output logic [BITSIZE-1:0] read_data2,
  output logic [BITSIZE-1:0] dbg_data,
  output logic [15:0]        write_count
);
  localparam int NREG = 2**REGSIZE;
  localparam int NWR  = NREG - 1;
  localparam int NRD  = 3;

  typedef struct packed {
    logic               en;
    logic [REGSIZE-1:0] idx;
    logic [BITSIZE-1:0] data;
  } wr_req_t;

  wr_req_t                       wr_req;
  logic                          commit;
  logic [NWR-1:0][BITSIZE-1:0]   regs_q, regs_d;
  logic [NREG-1:0][BITSIZE-1:0]  regs_view;
  logic [15:0]                   cnt_q, cnt_d;
  logic [NRD-1:0][REGSIZE-1:0]   rd_idx;
  logic [NRD-1:0][BITSIZE-1:0]   rd_data;

  assign wr_req = '{en: RegWrite, idx: write_reg, data: write_data};
  // Writes aimed at XZR are dropped entirely and never bump the counter.
  assign commit = wr_req.en && (wr_req.idx != REGSIZE'(NWR));

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NWR; i++) begin
      if (commit && (wr_req.idx == REGSIZE'(i))) regs_d[i] = wr_req.data;
    end
    if (commit) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // XZR occupies the top slot of the read view as a constant zero, not a flop.
  assign regs_view = {BITSIZE'(0), regs_q};
  assign rd_idx    = {dbg_reg, read_reg2, read_reg1};

  // Reads see stored state only; no bypass from the write port.
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    rf_read_port #(.BITSIZE(BITSIZE), .REGSIZE(REGSIZE)) u_rd (
      .regs (regs_view),
      .idx  (rd_idx[g]),
      .data (rd_data[g])
    );
  end

  assign read_data1  = rd_data[0];
  assign read_data2  = rd_data[1];
  assign dbg_data    = rd_data[2];
  assign write_count = cnt_q;
endmodule
